// File: rtl/sdm_bitstream_source.sv
// Second-order sigma-delta modulator: 8-bit unsigned PCM in over valid/ready, 1-bit stream out,
// one new sample consumed every OSR clocks at the phase counter's load slot.
module sdm_bitstream_source #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OSR   = 64,
  parameter int unsigned ACC_W = 18
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             BIT_OUT,
  output logic             SAMPLE_TICK,
  output logic             UNDERRUN
);

  localparam int unsigned PhW  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int unsigned SumW = ACC_W + 2;
  localparam int          Half = 1 << (WIDTH - 1);
  localparam int          AccMax = (1 << (ACC_W - 1)) - 1;

  localparam logic [PhW-1:0]          PhLast    = PhW'(OSR - 1);
  localparam logic [WIDTH-1:0]        ActiveRst = WIDTH'(Half);
  localparam logic signed [SumW-1:0]  HalfS     = SumW'(Half);
  localparam logic signed [SumW-1:0]  SatHi     = SumW'(AccMax);
  localparam logic signed [SumW-1:0]  SatLo     = -SatHi;

  logic [PhW-1:0]          phase_q, phase_d;
  logic [WIDTH-1:0]        pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]        active_q, active_d;
  logic signed [ACC_W-1:0] i1_q, i1_d;
  logic signed [ACC_W-1:0] i2_q, i2_d;
  logic                    bit_q, bit_d;
  logic                    tick_q, tick_d;
  logic                    underrun_q, underrun_d;

  logic                    load_slot;
  logic                    xfer;
  logic signed [SumW-1:0]  x_ext, fb_ext, i1_ext, i2_ext, sum1, sum2;

  // Symmetric clamp so the integrators never wrap or change sign on overflow.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SumW-1:0] v);
    logic signed [SumW-1:0] c;
    c = v;
    if (v > SatHi) begin
      c = SatHi;
    end else if (v < SatLo) begin
      c = SatLo;
    end
    return c[ACC_W-1:0];
  endfunction

  always_comb begin
    load_slot    = (phase_q == PhLast);
    xfer         = DIN_VALID & ~pend_valid_q;
    phase_d      = load_slot ? '0 : phase_q + PhW'(1);

    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    tick_d       = 1'b0;
    underrun_d   = 1'b0;

    if (load_slot) begin
      if (pend_valid_q) begin
        active_d     = pend_q;
        pend_valid_d = 1'b0;
        tick_d       = 1'b1;
      end else begin
        underrun_d   = 1'b1;
      end
    end

    // A transfer can only coincide with a load slot when pending is empty, so it never
    // collides with the load above.
    if (xfer) begin
      pend_d       = DIN;
      pend_valid_d = 1'b1;
    end

    x_ext  = $signed({{(SumW - WIDTH){1'b0}}, active_q}) - HalfS;
    fb_ext = bit_q ? HalfS : -HalfS;
    i1_ext = $signed({{(SumW - ACC_W){i1_q[ACC_W-1]}}, i1_q});
    i2_ext = $signed({{(SumW - ACC_W){i2_q[ACC_W-1]}}, i2_q});

    sum1   = i1_ext + x_ext - fb_ext;
    sum2   = i2_ext + i1_ext - fb_ext;
    i1_d   = sat(sum1);
    i2_d   = sat(sum2);
    bit_d  = ~i2_d[ACC_W-1];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= ActiveRst;
      i1_q         <= '0;
      i2_q         <= '0;
      bit_q        <= 1'b0;
      tick_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      bit_q        <= bit_d;
      tick_q       <= tick_d;
      underrun_q   <= underrun_d;
    end
  end

  assign DIN_READY   = ~pend_valid_q;
  assign BIT_OUT     = bit_q;
  assign SAMPLE_TICK = tick_q;
  assign UNDERRUN    = underrun_q;

endmodule

// File: tb/tb_sdm_bitstream_source.sv
// Bench for sdm_bitstream_source: cycle-by-cycle comparison against an integer reference model
// plus directed checks of density, load-slot timing, handshake pacing and reset behaviour.
module tb_sdm_bitstream_source;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned OSR    = 64;
  localparam int unsigned ACC_W  = 18;
  localparam int          Half   = 1 << (WIDTH - 1);
  localparam int          AccMax = (1 << (ACC_W - 1)) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] DIN = '0;
  logic             DIN_VALID = 1'b0;
  logic             DIN_READY;
  logic             BIT_OUT;
  logic             SAMPLE_TICK;
  logic             UNDERRUN;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain integers and a queue standing in for the pending slot.
  int m_phase, m_active, m_i1, m_i2;
  bit m_bit, m_tick, m_und;
  int m_pend[$];

  int ones_cnt, tick_cnt, und_cnt, cyc;
  int xfer_cycles[$];

  always #5 CLK = ~CLK;

  sdm_bitstream_source #(
    .WIDTH (WIDTH),
    .OSR   (OSR),
    .ACC_W (ACC_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .DIN         (DIN),
    .DIN_VALID   (DIN_VALID),
    .DIN_READY   (DIN_READY),
    .BIT_OUT     (BIT_OUT),
    .SAMPLE_TICK (SAMPLE_TICK),
    .UNDERRUN    (UNDERRUN)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, observed, expected);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > AccMax) return AccMax;
    if (v < -AccMax) return -AccMax;
    return v;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_active = Half;
    m_i1     = 0;
    m_i2     = 0;
    m_bit    = 1'b0;
    m_tick   = 1'b0;
    m_und    = 1'b0;
    m_pend.delete();
  endtask

  task automatic clear_counts();
    ones_cnt = 0;
    tick_cnt = 0;
    und_cnt  = 0;
    xfer_cycles.delete();
  endtask

  // Compare the current cycle, advance the model with the applied inputs, clock once.
  task automatic step();
    int x, fb, n_i1, n_i2, n_active;
    bit n_tick, n_und;
    check("din_ready", {31'd0, DIN_READY}, {31'd0, m_pend.size() == 0});
    check("bit_out", {31'd0, BIT_OUT}, {31'd0, m_bit});
    check("sample_tick", {31'd0, SAMPLE_TICK}, {31'd0, m_tick});
    check("underrun", {31'd0, UNDERRUN}, {31'd0, m_und});
    ones_cnt += int'(BIT_OUT);
    tick_cnt += int'(SAMPLE_TICK);
    und_cnt  += int'(UNDERRUN);
    if (DIN_VALID && DIN_READY) xfer_cycles.push_back(cyc);

    x        = m_active - Half;
    fb       = m_bit ? Half : -Half;
    n_i1     = clampv(m_i1 + x - fb);
    n_i2     = clampv(m_i2 + m_i1 - fb);
    n_active = m_active;
    n_tick   = 1'b0;
    n_und    = 1'b0;
    if (m_phase == int'(OSR) - 1) begin
      if (m_pend.size() > 0) begin
        n_active = m_pend.pop_front();
        n_tick   = 1'b1;
      end else begin
        n_und    = 1'b1;
      end
    end else if (DIN_VALID && m_pend.size() == 0) begin
      m_pend.push_back(int'(DIN));
    end
    if (m_phase == int'(OSR) - 1 && n_und && DIN_VALID) m_pend.push_back(int'(DIN));

    @(posedge CLK);
    #1;
    m_phase  = (m_phase + 1) % int'(OSR);
    m_active = n_active;
    m_i1     = n_i1;
    m_i2     = n_i2;
    m_bit    = (n_i2 >= 0);
    m_tick   = n_tick;
    m_und    = n_und;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit"}, {31'd0, BIT_OUT}, 32'd0);
    check({tag, "_tick"}, {31'd0, SAMPLE_TICK}, 32'd0);
    check({tag, "_und"}, {31'd0, UNDERRUN}, 32'd0);
    check({tag, "_ready"}, {31'd0, DIN_READY}, 32'd1);
  endtask

  initial begin
    int nxt, p;
    bit found;
    cyc = 0;
    model_reset();
    clear_counts();

    // Power-on reset, released just after an edge.
    #2;
    check_reset_outputs("por");
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // 1: idle from reset; load slot at cycle 63 finds nothing.
    for (int i = 0; i < 64; i++) step();
    check("t1_density_32pm1", {31'd0, (ones_cnt >= 31 && ones_cnt <= 33)}, 32'd1);
    check("t1_no_early_underrun", und_cnt, 0);
    check("t1_underrun_clk64", {31'd0, UNDERRUN}, 32'd1);
    step();

    // 2: steady DIN=192.
    DIN = 8'd192;
    DIN_VALID = 1'b1;
    for (int i = 0; i < 256; i++) step();
    clear_counts();
    for (int i = 0; i < 1024; i++) step();
    check("t2_density_768pm4", {31'd0, (ones_cnt >= 764 && ones_cnt <= 772)}, 32'd1);
    check("t2_ticks", tick_cnt, 16);
    check("t2_underruns", und_cnt, 0);

    // 3: full-scale negative then full-scale positive.
    DIN = 8'd0;
    for (int i = 0; i < 1024; i++) step();
    clear_counts();
    for (int i = 0; i < 1024; i++) step();
    check("t3_ones_din0", ones_cnt, 0);
    DIN = 8'd255;
    for (int i = 0; i < 1024; i++) step();
    clear_counts();
    for (int i = 0; i < 1024; i++) step();
    check("t3_ones_din255_ge1016", {31'd0, ones_cnt >= 1016}, 32'd1);

    // 4: valid held high, DIN scrambled while not ready, incrementing on each accept.
    nxt = 10;
    clear_counts();
    for (int i = 0; i < 9 * int'(OSR); i++) begin
      found = (m_pend.size() == 0);
      DIN = found ? WIDTH'(nxt) : WIDTH'($urandom);
      step();
      if (found) nxt++;
    end
    check("t4_xfer_count", xfer_cycles.size(), 9);
    check("t4_tick_count", tick_cnt, 9);
    for (int i = 1; i < xfer_cycles.size(); i++)
      check("t4_xfer_gap", xfer_cycles[i] - xfer_cycles[i-1], int'(OSR));

    // 5: drain pending, then transfer exactly on a load slot.
    DIN_VALID = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 * int'(OSR); i++) begin
      if (m_pend.size() == 0 && m_phase == int'(OSR) - 1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t5_reached_empty_slot", {31'd0, found}, 32'd1);
    DIN = WIDTH'($urandom_range(0, 255));
    DIN_VALID = 1'b1;
    step();
    DIN_VALID = 1'b0;
    check("t5_underrun", {31'd0, UNDERRUN}, 32'd1);
    for (int i = 0; i < int'(OSR); i++) step();
    check("t5_tick_next_slot", {31'd0, SAMPLE_TICK}, 32'd1);

    // 6: randomized traffic with varying offered load.
    for (int c = 0; c < 6; c++) begin
      p = $urandom_range(1, 100);
      for (int i = 0; i < 500; i++) begin
        DIN_VALID = ($urandom_range(1, 100) <= p);
        DIN = WIDTH'($urandom);
        step();
      end
    end

    // 7: asynchronous reset mid-period with pending full.
    DIN = 8'd200;
    DIN_VALID = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3 * int'(OSR); i++) begin
      if (m_pend.size() == 1 && m_phase == 20) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t7_pending_full", {31'd0, found}, 32'd1);
    #3;
    RST = 1'b0;
    #1;
    check_reset_outputs("t7_in_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check_reset_outputs("t7_held");
    end
    DIN_VALID = 1'b0;
    model_reset();
    RST = 1'b1;
    clear_counts();
    for (int i = 0; i < 64; i++) step();
    check("t7_no_tick_after_reset", tick_cnt, 0);
    check("t7_underrun_first_slot", {31'd0, UNDERRUN}, 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
